mssd_frame_scheduler: RTL and testbench
=======================================

// Module: mssd_frame_scheduler
// PURPOSE
//  Shares the single MSSD serial line between 4 requesters and serializes one frame at a time.
//  Frame format: start 0, 2-bit port id MSB-first, 4-bit count MSB-first, then count+1 data bits.
//  Arbitration is round-robin. serOut drives the MSSD serIn input directly, one bit per clk.
// PARAMETERS
//  IDLE_GAP  2  serOut high cycles forced after each frame's last data bit (>=1)
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  rst      in   1   asynchronous, active-high reset
//  req      in   4   req[i]: port i has a frame pending; hold until done[i]
//  len      in   16  len[4i+3:4i]: port i count field; frame carries len+1 data bits
//  data     in   64  data[16i+15:16i]: port i payload, bit 0 transmitted first
//  serOut   out  1   serial line to MSSD, registered, idles high
//  busy     out  1   high from START through last GAP cycle
//  grant    out  4   one-hot owner, START through last data bit, else 0
//  done     out  4   done[i]: 1-cycle pulse on the first GAP cycle of port i's frame
// BEHAVIOUR
//  Reset (async, any state): serOut=1, busy=0, grant=0, done=0, state=IDLE, rr pointer=port 0.
//  States: IDLE -> START -> ID(2) -> CNT(4) -> DATA(len+1) -> GAP(IDLE_GAP) -> IDLE.
//  IDLE: serOut=1. On an edge with |req: pick winner, latch id/len/data, enter START.
//   serOut=0 and grant valid from that same edge.
//  Arbitration: search starts at port (last_winner+1) mod 4. After reset, search starts at port 0.
//   The pointer updates only when a frame is granted.
//  START: 1 cycle, serOut=0.
//  ID: 2 cycles, id[1] then id[0].
//  CNT: 4 cycles, len[3]..len[0].
//  DATA: len+1 cycles, data[0] first. Bit counter is 4-bit; len=15 gives 16 bits with no wrap error.
//  Total frame = 7+len+1 cycles (8..23). Next START comes no earlier than IDLE_GAP cycles later.
//  GAP: serOut=1, busy=1, grant=0. done pulses on the first GAP cycle only.
//  Payload is latched at grant. req/len/data changes after grant have no effect on the frame.
//  Dropping req mid-frame does not abort the frame; done still pulses.
//  req[i] held through GAP: port i is re-arbitrated in IDLE with rotated priority.
//  Never grants while busy. Only one frame is in flight.
//  Reset mid-frame: line returns high at once and no done is issued.
//   The downstream MSSD sees a truncated frame and must itself be reset.
// TESTING
//  1. req=0010, len1=3, data1[3:0]=4'b1011:
//     serOut = 0,0,1,0,0,1,1,1,1,0,1 then >=2 ones; done=0010 once; grant=0010 for 11 cycles.
//  2. req=1111 after reset, all len=0:
//     frames ordered ports 0,1,2,3; each frame is 8 cycles; exactly 2 high cycles between frames.
//  3. req[0] and req[2] held high continuously: grants alternate 0,2,0,2; ports 1 and 3 never granted.
//  4. len=0 then len=15: 8- and 23-cycle frames.
//     Data changed right after grant: transmitted bits still equal the latched value.
//  5. rst pulsed in DATA of port 3: serOut=1 and grant=0 immediately, no done.
//     Next req=1001 grants port 0 first.
//  6. Loopback to MSSD with random req/len/data (>=200 frames):
//     MSSD d matches sent id; p stream matches sent data; error never asserts.

Source files
------------

// File: rtl/mssd_frame_scheduler.sv
// Round-robin scheduler that shares one MSSD serial line between four requesters,
// serializing a latched frame (start, id, count, data) followed by a forced idle gap.
module mssd_frame_scheduler #(
   parameter int IDLE_GAP = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [15:0] len,
   input  logic [63:0] data,
   output logic        serOut,
   output logic        busy,
   output logic [3:0]  grant,
   output logic [3:0]  done
);

   localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

   typedef enum logic [2:0] {IDLE, START, ID, CNT, DATA, GAP} state_t;

   state_t          state, stateNext;
   logic [3:0]      cnt, cntNext;
   logic [GW-1:0]   gapCnt, gapCntNext;
   logic [1:0]      idReg, idNext;
   logic [3:0]      lenReg, lenNext;
   logic [15:0]     dataReg, dataNext;
   logic [1:0]      rrPtr, rrNext;
   logic            serNext, busyNext;
   logic [3:0]      grantNext, doneNext;
   logic            found, launch;
   logic [1:0]      winner;

   // Round-robin search starting at rrPtr; rrPtr always names the port after the last winner.
   always_comb begin
      found  = 1'b0;
      winner = rrPtr;
      for (int k = 0; k < 4; k++) begin
         if (!found && req[rrPtr + 2'(k)]) begin
            found  = 1'b1;
            winner = rrPtr + 2'(k);
         end
      end
   end

   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      gapCntNext = gapCnt;
      idNext     = idReg;
      lenNext    = lenReg;
      dataNext   = dataReg;
      rrNext     = rrPtr;
      serNext    = serOut;
      busyNext   = busy;
      grantNext  = grant;
      doneNext   = 4'b0000;
      launch     = 1'b0;
      // cnt holds the index of the bit currently on the line in ID/CNT/DATA.
      case (state)
         IDLE: begin
            serNext   = 1'b1;
            busyNext  = 1'b0;
            grantNext = 4'b0000;
            launch    = found;
         end
         START: begin
            stateNext = ID;
            serNext   = idReg[1];
            cntNext   = 4'd1;
         end
         ID: begin
            if (cnt == 4'd1) begin
               serNext = idReg[0];
               cntNext = 4'd0;
            end else begin
               stateNext = CNT;
               serNext   = lenReg[3];
               cntNext   = 4'd3;
            end
         end
         CNT: begin
            if (cnt != 4'd0) begin
               serNext = lenReg[cnt - 4'd1];
               cntNext = cnt - 4'd1;
            end else begin
               stateNext = DATA;
               serNext   = dataReg[0];
               cntNext   = 4'd0;
            end
         end
         DATA: begin
            if (cnt != lenReg) begin
               serNext = dataReg[cnt + 4'd1];
               cntNext = cnt + 4'd1;
            end else begin
               stateNext  = GAP;
               serNext    = 1'b1;
               grantNext  = 4'b0000;
               doneNext   = 4'b0001 << idReg;
               gapCntNext = GW'(IDLE_GAP - 1);
            end
         end
         GAP: begin
            serNext = 1'b1;
            if (gapCnt != '0) begin
               gapCntNext = gapCnt - 1'b1;
            end else begin
               // Last gap cycle: a pending request starts the next frame without an extra idle cycle.
               stateNext = IDLE;
               busyNext  = 1'b0;
               launch    = found;
            end
         end
         default: begin
            stateNext = IDLE;
            serNext   = 1'b1;
            busyNext  = 1'b0;
            grantNext = 4'b0000;
         end
      endcase
      if (launch) begin
         stateNext = START;
         serNext   = 1'b0;
         busyNext  = 1'b1;
         grantNext = 4'b0001 << winner;
         idNext    = winner;
         lenNext   = len[{winner, 2'b00} +: 4];
         dataNext  = data[{winner, 4'b0000} +: 16];
         rrNext    = winner + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         gapCnt  <= '0;
         idReg   <= 2'd0;
         lenReg  <= 4'd0;
         dataReg <= 16'd0;
         rrPtr   <= 2'd0;
         serOut  <= 1'b1;
         busy    <= 1'b0;
         grant   <= 4'b0000;
         done    <= 4'b0000;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         gapCnt  <= gapCntNext;
         idReg   <= idNext;
         lenReg  <= lenNext;
         dataReg <= dataNext;
         rrPtr   <= rrNext;
         serOut  <= serNext;
         busy    <= busyNext;
         grant   <= grantNext;
         done    <= doneNext;
      end
   end

endmodule

// File: tb/tb_mssd_frame_scheduler.sv
// Bench for mssd_frame_scheduler: directed scenarios then random traffic, each cycle
// checked against a frame-level reference model of the serial line and handshake outputs.
module tb_mssd_frame_scheduler;

   localparam int IDLE_GAP = 2;
   localparam logic [9:0] IDLE_V = 10'b1_0_0000_0000;  // {serOut, busy, grant, done}

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] len;
   logic [63:0] data;
   logic        serOut;
   logic        busy;
   logic [3:0]  grant;
   logic [3:0]  done;

   int          nCompared = 0;
   int          nMismatched = 0;
   logic [9:0]  expQ[$];
   int          rrModel = 0;
   int          owner = -1;
   int          framesDone = 0;
   int          dutFrames = 0;
   bit          autoDrop = 1'b1;

   mssd_frame_scheduler #(.IDLE_GAP(IDLE_GAP)) dut (
      .clk(clk), .rst(rst), .req(req), .len(len), .data(data),
      .serOut(serOut), .busy(busy), .grant(grant), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
      nCompared++;
      assert (obs === expv) else begin
         nMismatched++;
         $error("FAIL %s observed={ser,busy,grant,done}=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Frame as seen on the line: START, id MSB-first, count MSB-first, len+1 data LSB-first, gap.
   function automatic void buildFrame(input logic [3:0] r, input logic [15:0] l16, input logic [63:0] d64);
      int w;
      logic [1:0] id;
      logic [3:0] l;
      logic [15:0] d;
      logic [3:0] oh;
      w = -1;
      for (int k = 0; k < 4; k++) begin
         int p;
         p = (rrModel + k) % 4;
         if (w < 0 && r[p]) w = p;
      end
      rrModel = (w + 1) % 4;
      owner = w;
      id = 2'(w);
      l = l16[4*w +: 4];
      d = d64[16*w +: 16];
      oh = 4'(1 << w);
      expQ.push_back({1'b0, 1'b1, oh, 4'b0000});
      expQ.push_back({id[1], 1'b1, oh, 4'b0000});
      expQ.push_back({id[0], 1'b1, oh, 4'b0000});
      for (int b = 3; b >= 0; b--) expQ.push_back({l[b], 1'b1, oh, 4'b0000});
      for (int b = 0; b <= int'(l); b++) expQ.push_back({d[b], 1'b1, oh, 4'b0000});
      expQ.push_back({1'b1, 1'b1, 4'b0000, oh});
      for (int g = 1; g < IDLE_GAP; g++) expQ.push_back({1'b1, 1'b1, 4'b0000, 4'b0000});
   endfunction

   task automatic step(input string tag);
      logic [3:0]  sReq;
      logic [15:0] sLen;
      logic [63:0] sData;
      logic [9:0]  e;
      sReq = req;
      sLen = len;
      sData = data;
      @(posedge clk);
      #1;
      if (expQ.size() == 0 && sReq != 4'b0000) buildFrame(sReq, sLen, sData);
      if (expQ.size() != 0) e = expQ.pop_front();
      else e = IDLE_V;
      check(tag, {serOut, busy, grant, done}, e);
      if (done != 4'b0000) dutFrames++;
      if (e[3:0] != 4'b0000) begin
         framesDone++;
         owner = -1;
         if (autoDrop) req = req & ~e[3:0];
      end
   endtask

   task automatic runUntil(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (dutFrames < target && n < budget) begin
         step(tag);
         n++;
      end
      nCompared++;
      assert (dutFrames >= target) else begin
         nMismatched++;
         $error("FAIL %s_timeout done_pulses=%0d expected=%0d", tag, dutFrames, target);
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 40) begin
         step(tag);
         n++;
      end
      repeat (3) step(tag);
   endtask

   task automatic doReset(input string tag);
      req = 4'b0000;
      rst = 1'b1;
      #2;
      check(tag, {serOut, busy, grant, done}, IDLE_V);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expQ.delete();
      rrModel = 0;
      owner = -1;
      framesDone = 0;
      dutFrames = 0;
      autoDrop = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      req = 4'b0000;
      len = 16'h0000;
      data = 64'h0;
      #1;
      doReset("reset_state");
      repeat (2) step("idle_after_reset");

      // Port 1, len 3, payload 1011: line reads 0,0,1,0,0,1,1,1,1,0,1.
      len = 16'h0030;
      data = 64'h0000_0000_000B_0000;
      req = 4'b0010;
      runUntil(1, 40, "t1_single");
      drain("t1_tail");

      // All four requesting from reset: ports 0..3 in order, 2 high cycles between frames.
      doReset("t2_reset");
      len = 16'h0000;
      data = {$urandom, $urandom};
      req = 4'b1111;
      runUntil(4, 60, "t2_rr_order");
      drain("t2_tail");

      // Ports 0 and 2 held continuously: strict alternation, 1 and 3 never granted.
      doReset("t3_reset");
      autoDrop = 1'b0;
      len = 16'h0505;
      data = {$urandom, $urandom};
      req = 4'b0101;
      runUntil(6, 120, "t3_alternate");
      req = 4'b0000;
      autoDrop = 1'b1;
      drain("t3_tail");

      // Shortest then longest frame; payload scrambled right after grant.
      doReset("t4_reset");
      len = 16'h0000;
      data = {$urandom, $urandom};
      req = 4'b0001;
      runUntil(1, 30, "t4_len0");
      drain("t4_len0_tail");
      len = 16'h000F;
      req = 4'b0001;
      step("t4_len15_grant");
      data = {$urandom, $urandom};
      len = 16'($urandom);
      runUntil(2, 40, "t4_len15");
      drain("t4_len15_tail");

      // Reset during port 3's data phase: line high at once, no done, pointer back to port 0.
      doReset("t5_reset");
      len = 16'hA000;
      data = {$urandom, $urandom};
      req = 4'b1000;
      repeat (10) step("t5_pre_rst");
      req = 4'b0000;
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_mid_frame", {serOut, busy, grant, done}, IDLE_V);
      #2;
      rst = 1'b0;
      expQ.delete();
      rrModel = 0;
      owner = -1;
      dutFrames = 0;
      framesDone = 0;
      repeat (4) step("t5_no_done");
      len = {$urandom}[15:0];
      req = 4'b1001;
      runUntil(2, 70, "t5_after_rst");
      drain("t5_tail");

      // Random traffic: pending payloads churn until grant, owners may drop req mid-frame.
      doReset("t6_reset");
      while (framesDone < 200 && nCompared < 20000) begin
         for (int i = 0; i < 4; i++) begin
            if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
         end
         if ($urandom_range(0, 1) == 0) begin
            len = 16'($urandom);
            data = {$urandom, $urandom};
         end
         if (owner >= 0 && $urandom_range(0, 15) == 0) req[owner] = 1'b0;
         step("t6_random");
      end
      req = 4'b0000;
      drain("t6_tail");
      nCompared++;
      assert (dutFrames >= 200) else begin
         nMismatched++;
         $error("FAIL t6_frame_count done_pulses=%0d expected>=%0d", dutFrames, 200);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
